// File: rtl/sc_pkg.sv
// Shared definitions for the sc counter family: default width and the
// state encoding used by the down-counter/timer.
package sc_pkg;

  localparam int SC_WIDTH_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/sc_down.sv
// Loadable synchronous down-counter/timer. Counts down on en, pulses tc for
// one cycle on the zero-reach edge, then reloads (periodic) or parks in DONE
// (one-shot).
//
// state | meaning
// IDLE  | after reset; waits for load, en ignored, count held
// RUN   | counting; load re-arms, en decrements, zero+en fires tc
// DONE  | one-shot expired; count held at 0, waits for load
module sc_down
  import sc_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  output logic [WIDTH-1:0] r_reg,
  output logic             tc,
  output logic             busy
);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_rld;
  logic             r_tc;
  logic             w_zero;

  assign w_zero = (r_reg == '0);

  // State, count, reload value and terminal-count pulse; reset > load > count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_reg   <= '0;
      r_rld   <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (load) begin
            r_reg   <= load_val;
            r_rld   <= load_val;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (load) begin
            r_reg <= load_val;
            r_rld <= load_val;
          end else if (en) begin
            if (!w_zero) begin
              r_reg <= r_reg - 1'b1;
            end else begin
              // Zero-reach edge: oneshot is only looked at here.
              r_tc <= 1'b1;
              if (oneshot) begin
                r_state <= ST_DONE;
              end else begin
                r_reg <= r_rld;
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_reg   <= '0;
        end
      endcase
    end
  end

  assign tc   = r_tc;
  assign busy = (r_state == ST_RUN);

endmodule

// File: tb/tb_sc_down.sv
// Directed bench for sc_down: stimulus pushes hand-computed expectations into
// a scoreboard queue, a monitor pops one per clock and compares.
module tb_sc_down;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic         oneshot;
  logic [W-1:0] r_reg;
  logic         tc;
  logic         busy;

  typedef struct {
    logic [W-1:0] r;
    logic         t;
    logic         b;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_total = 0;
  int   n_bad   = 0;

  sc_down #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .oneshot  (oneshot),
    .r_reg    (r_reg),
    .tc       (tc),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Monitor: after every rising edge, check outputs against the next entry.
  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      n_total++;
      if (r_reg !== m_e.r || tc !== m_e.t || busy !== m_e.b) begin
        n_bad++;
        $display("FAIL %s: got r_reg=%0d tc=%0b busy=%0b, want r_reg=%0d tc=%0b busy=%0b",
                 m_e.name, r_reg, tc, busy, m_e.r, m_e.t, m_e.b);
      end
    end
  end

  task automatic step(input logic rs, input logic ld, input logic [W-1:0] lv,
                      input logic e, input logic os,
                      input logic [W-1:0] xr, input logic xt, input logic xb,
                      input string nm);
    exp_t x;
    @(negedge clk);
    reset = rs; load = ld; load_val = lv; en = e; oneshot = os;
    x.r = xr; x.t = xt; x.b = xb; x.name = nm;
    sb.push_back(x);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; oneshot = 1'b0;

    // Reset wins over load
    step(1, 1, 9, 1, 0, 0, 0, 0, "reset0");
    step(1, 1, 9, 1, 0, 0, 0, 0, "reset1");

    // Periodic count of 3: 3,2,1,0,3,2,1,0,3
    step(0, 1, 3, 0, 0, 3, 0, 1, "per_load");
    step(0, 0, 0, 1, 0, 2, 0, 1, "per_2a");
    step(0, 0, 0, 1, 0, 1, 0, 1, "per_1a");
    step(0, 0, 0, 1, 0, 0, 0, 1, "per_0a");
    step(0, 0, 0, 1, 0, 3, 1, 1, "per_tc1");
    step(0, 0, 0, 1, 0, 2, 0, 1, "per_2b");
    step(0, 0, 0, 1, 0, 1, 0, 1, "per_1b");
    step(0, 0, 0, 1, 0, 0, 0, 1, "per_0b");
    step(0, 0, 0, 1, 0, 3, 1, 1, "per_tc2");

    // One-shot with enable gap: 2,1,1,1,0,0 then DONE
    step(0, 1, 2, 0, 1, 2, 0, 1, "os_load");
    step(0, 0, 0, 1, 1, 1, 0, 1, "os_en1");
    step(0, 0, 0, 0, 1, 1, 0, 1, "os_gap1");
    step(0, 0, 0, 0, 1, 1, 0, 1, "os_gap2");
    step(0, 0, 0, 1, 1, 0, 0, 1, "os_en2");
    step(0, 0, 0, 1, 1, 0, 1, 0, "os_tc");
    step(0, 0, 0, 1, 1, 0, 0, 0, "os_done1");
    step(0, 0, 0, 1, 0, 0, 0, 0, "os_done2");

    // Load collision at zero in RUN
    step(0, 1, 1, 0, 0, 1, 0, 1, "col_load");
    step(0, 0, 0, 1, 0, 0, 0, 1, "col_zero");
    step(0, 1, 5, 1, 0, 5, 0, 1, "col_reload");
    step(0, 0, 0, 1, 0, 4, 0, 1, "col_dec");

    // Mid-count reset
    step(0, 1, 15, 0, 0, 15, 0, 1, "mr_load");
    step(0, 0, 0, 1, 0, 14, 0, 1, "mr_14");
    step(0, 0, 0, 1, 0, 13, 0, 1, "mr_13");
    step(0, 0, 0, 1, 0, 12, 0, 1, "mr_12");
    step(0, 0, 0, 1, 0, 11, 0, 1, "mr_11");
    step(1, 0, 0, 1, 0, 0, 0, 0, "mr_reset");
    step(0, 0, 0, 1, 0, 0, 0, 0, "mr_idle_en1");
    step(0, 0, 0, 1, 0, 0, 0, 0, "mr_idle_en2");

    // Load 0 periodic: tc every enabled cycle, gap gives no tc
    step(0, 1, 0, 0, 0, 0, 0, 1, "z_load");
    step(0, 0, 0, 1, 0, 0, 1, 1, "z_tc1");
    step(0, 0, 0, 1, 0, 0, 1, 1, "z_tc2");
    step(0, 0, 0, 0, 0, 0, 0, 1, "z_gap");
    step(0, 0, 0, 1, 0, 0, 1, 1, "z_tc3");

    // Load 15: tc on the 16th enabled cycle with reload to 15
    step(0, 1, 15, 1, 0, 15, 0, 1, "f_load");
    for (int i = 1; i <= 15; i++)
      step(0, 0, 0, 1, 0, W'(15 - i), 0, 1, "f_dec");
    step(0, 0, 0, 1, 0, 15, 1, 1, "f_tc");
    step(0, 0, 0, 0, 0, 15, 0, 1, "f_hold");

    @(posedge clk);
    #5;
    n_total++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending entries, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sc_down.md
Name: sc_down

Overview:
- Loadable synchronous down-counter/timer. It is the counting-down counterpart of the existing 4-bit up-counter `sc` and uses the same `en`/`clk`/`reset`/`r_reg` interface style.
- It is loaded with a start value and decrements on `en`. On reaching zero it pulses terminal count, then either reloads (periodic mode) or stops (one-shot mode).
- It sits beside `sc` in the flip-flop/counter library and generates periodic ticks or timeouts for other blocks.

Parameters:
- WIDTH, 4, counter and load-value width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; decrement happens only when high.
- load  input  1  parallel-load strobe; takes priority over `en`.
- load_val  input  WIDTH  start/reload value, captured when `load`=1.
- oneshot  input  1  1 = stop at zero; 0 = reload and continue. Sampled only on the zero-reach edge.
- r_reg  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, exactly one cycle wide.
- busy  output  1  high while the FSM is in RUN.

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-high on port `reset`.
- Priority at each edge: reset > load > count.
- Reset: on an edge with `reset`=1:
  - state goes to IDLE;
  - `r_reg`=0, the reload register `rld`=0, `tc`=0, `busy`=0;
  - this applies mid-count too; there is no partial effect.
- FSM states: IDLE, RUN, DONE. `busy` = (state==RUN), decoded from the state register.
- IDLE:
  - `en` is ignored and `r_reg` holds.
  - `load`=1 → `r_reg`<=`load_val`, `rld`<=`load_val`, go to RUN.
- RUN, `load`=1: re-load exactly as in IDLE, stay in RUN, `tc`=0 that edge. This applies even if `r_reg`==0 at the same edge.
- RUN, `load`=0, `en`=0: hold `r_reg`; `tc`=0.
- RUN, `load`=0, `en`=1, `r_reg`!=0: `r_reg`<=`r_reg`-1; `tc`=0.
- RUN, `load`=0, `en`=1, `r_reg`==0:
  - `tc`<=1 for that edge only.
  - If `oneshot`=0: `r_reg`<=`rld` and stay in RUN.
  - If `oneshot`=1: `r_reg` stays 0 and go to DONE.
- DONE:
  - `r_reg` holds 0, `en` is ignored, `tc`=0.
  - `load`=1 → re-load and go to RUN.
- Period: after loading N, `tc` fires after N+1 enabled cycles. In periodic mode, `tc` then repeats every N+1 enabled cycles.
- Loading 0:
  - `tc` fires on the first enabled cycle.
  - Periodic mode with `rld`=0 gives `tc` on every enabled cycle.
- Arithmetic: unsigned, WIDTH bits. Decrement from 0 never occurs, because the zero branch takes precedence. No wrap through 2^WIDTH-1 unless `rld` = 2^WIDTH-1.
- Latency: `load` takes effect in `r_reg` one edge after it is sampled. `tc` is visible in the cycle following the zero-reach edge, coincident with the reloaded value.
- `en` gaps freeze the count and do not generate a spurious `tc`.

Decomposition:
- Shared package `sc_pkg`:
  - FSM state encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - default WIDTH constant.
- Single module; no sub-module needed.
- An optional `sc_down_tb` bench follows the existing testbench style: 20 ns clock period, `$monitor` trace.

Test Plan (WIDTH=4 for all scenarios):
- Reset: `reset`=1 for 2 cycles with `load`=1, `load_val`=9 → `r_reg`=0, `tc`=0, `busy`=0 throughout. Reset wins.
- Periodic count: load 3, `oneshot`=0, `en`=1 → `r_reg` sequence 3,2,1,0,3,2,1,0,3. `tc`=1 exactly on the cycles showing the reload value 3; `busy`=1 throughout.
- One-shot with an enable gap: load 2, `oneshot`=1, `en` pattern 1,0,0,1,1 → `r_reg` 2,1,1,1,0,0. `tc` fires once after the final enabled zero cycle. State goes to DONE, `busy`=0, `r_reg` holds 0 with `en`=1.
- Load collision: in RUN with `r_reg`=0 and `en`=1, assert `load`=1, `load_val`=5 → next `r_reg`=5, `tc`=0, state stays RUN.
- Mid-count reset: load 15, `en`=1 for 4 cycles (`r_reg`=11), then `reset`=1 for one edge → `r_reg`=0, IDLE. A subsequent `en` alone does not change `r_reg`.
- Edge values: load 0 periodic → `tc`=1 every enabled cycle and `r_reg` stays 0. Then load 15 → `tc` fires after 16 enabled cycles, with `r_reg` reloading to 15.
